mem_arbiter: RTL

// - Sole owner of the byte-wide RAM port. Shares it between three requesters: instruction fetch (IF),

---
 rtl/mem_arbiter_pkg.sv | 43 ++++
 rtl/mem_arbiter_if.sv | 65 ++++++
 rtl/mem_load_ext.sv | 26 ++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_arbiter_pkg
// Description : Shared instruction-type codes, FSM encodings and beat helper
//               for the byte-wide RAM arbiter.
// Revision    : 1.0
// ============================================================================
package mem_arbiter_pkg;

    localparam int c_INST_TYPE_W = 3;
    typedef logic [c_INST_TYPE_W-1:0] inst_type_t;

    localparam inst_type_t c_LB  = 3'd0;
    localparam inst_type_t c_LH  = 3'd1;
    localparam inst_type_t c_LW  = 3'd2;
    localparam inst_type_t c_LBU = 3'd3;
    localparam inst_type_t c_LHU = 3'd4;
    localparam inst_type_t c_SB  = 3'd5;
    localparam inst_type_t c_SH  = 3'd6;
    localparam inst_type_t c_SW  = 3'd7;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2,
        OWN_ST   = 2'd3
    } owner_e;

    function automatic logic [2:0] beat_count(input inst_type_t t);
        case (t)
            c_LB, c_LBU, c_SB: beat_count = 3'd1;
            c_LH, c_LHU, c_SH: beat_count = 3'd2;
            default:           beat_count = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : mem_arbiter_if
// Description : Requester (IF/LD/ST), control and byte-wide RAM signals of
//               the memory arbiter.
// Revision    : 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    import mem_arbiter_pkg::*;

    logic              rdy_in;
    logic              flush_in;
    logic              io_buffer_full_in;

    logic              if_en_in;
    logic [ADDR_W-1:0] if_addr_in;
    logic              if_finish_out;
    logic [31:0]       if_data_out;

    logic              lb_en_in;
    logic [ADDR_W-1:0] lb_addr_in;
    inst_type_t        lb_type_in;
    logic              lb_finish_out;
    logic [31:0]       lb_data_out;

    logic              st_en_in;
    logic [ADDR_W-1:0] st_addr_in;
    logic [31:0]       st_data_in;
    inst_type_t        st_type_in;
    logic              st_rdy_out;
    logic              st_finish_out;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport slave (
        input  rdy_in, flush_in, io_buffer_full_in,
        input  if_en_in, if_addr_in,
        output if_finish_out, if_data_out,
        input  lb_en_in, lb_addr_in, lb_type_in,
        output lb_finish_out, lb_data_out,
        input  st_en_in, st_addr_in, st_data_in, st_type_in,
        output st_rdy_out, st_finish_out,
        input  mem_din,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy_in, flush_in, io_buffer_full_in,
        output if_en_in, if_addr_in,
        input  if_finish_out, if_data_out,
        output lb_en_in, lb_addr_in, lb_type_in,
        input  lb_finish_out, lb_data_out,
        output st_en_in, st_addr_in, st_data_in, st_type_in,
        input  st_rdy_out, st_finish_out,
        output mem_din,
        input  mem_dout, mem_a, mem_wr
    );

endinterface
`default_nettype wire

// File: rtl/mem_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_ext
// Description : Sign/zero extension of assembled load data by load type.
// Revision    : 1.0
// ============================================================================
module mem_load_ext
    import mem_arbiter_pkg::*;
(
    input  inst_type_t  i_type,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    always_comb begin
        case (i_type)
            c_LB:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
            c_LH:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
            c_LBU:   o_data = {24'b0, i_raw[7:0]};
            c_LHU:   o_data = {16'b0, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Fixed-priority (ST > LD > IF) arbiter serialising word/half/
//               byte accesses onto a byte-wide RAM port.
// Revision    : 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter logic [17:0] IO_BASE = 18'h30000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] c_IO_TAG = IO_BASE[17:16];

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    owner_e            r_owner;
    logic [ADDR_W-1:0] r_addr;
    inst_type_t        r_type;
    logic [31:0]       r_data;
    logic [31:0]       r_raw;

    logic [2:0]        w_beats;
    logic [ADDR_W-1:0] w_beat_addr;
    logic [1:0]        w_cap_idx;
    logic              w_stall;
    logic              w_capture;
    logic              w_grant_st;
    logic              w_grant_ld;
    logic              w_grant_if;
    logic [31:0]       w_ext;

    assign w_beats     = beat_count(r_type);
    assign w_beat_addr = r_addr + {{(ADDR_W-3){1'b0}}, r_cnt};
    assign w_stall     = (w_beat_addr[17:16] == c_IO_TAG) && bus.io_buffer_full_in;
    // RAM data lags its address by one cycle, so capture targets the previous beat
    assign w_cap_idx   = r_cnt[1:0] - 2'd1;

    mem_load_ext u_load_ext (
        .i_type (r_type),
        .i_raw  (r_raw),
        .o_data (w_ext)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= c_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_owner <= OWN_NONE;
            r_addr  <= '0;
            r_type  <= c_LB;
            r_data  <= '0;
            r_raw   <= '0;
        end else begin
            if (w_grant_st) begin
                r_owner <= OWN_ST;
                r_addr  <= bus.st_addr_in;
                r_type  <= bus.st_type_in;
                r_data  <= bus.st_data_in;
            end else if (w_grant_ld) begin
                r_owner <= OWN_LD;
                r_addr  <= bus.lb_addr_in;
                r_type  <= bus.lb_type_in;
            end else if (w_grant_if) begin
                r_owner <= OWN_IF;
                r_addr  <= bus.if_addr_in;
                r_type  <= c_LW;
            end
            if (w_capture) begin
                r_raw[{w_cap_idx, 3'b000} +: 8] <= bus.mem_din;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_grant_st  = 1'b0;
        w_grant_ld  = 1'b0;
        w_grant_if  = 1'b0;
        if (bus.rdy_in) begin
            case (r_state)
                c_IDLE: begin
                    w_cnt_nxt = 3'd0;
                    if (bus.st_en_in) begin
                        w_grant_st  = 1'b1;
                        w_state_nxt = c_WRITE;
                    end else if (!bus.flush_in && bus.lb_en_in) begin
                        w_grant_ld  = 1'b1;
                        w_state_nxt = c_READ;
                    end else if (!bus.flush_in && bus.if_en_in) begin
                        w_grant_if  = 1'b1;
                        w_state_nxt = c_READ;
                    end
                end
                c_READ: begin
                    if (bus.flush_in) begin
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_capture = (r_cnt != 3'd0);
                        if (r_cnt == w_beats) begin
                            w_state_nxt = c_DONE;
                            w_cnt_nxt   = 3'd0;
                        end else begin
                            w_cnt_nxt = r_cnt + 3'd1;
                        end
                    end
                end
                c_WRITE: begin
                    if (!w_stall) begin
                        if (r_cnt == w_beats - 3'd1) begin
                            w_state_nxt = c_DONE;
                            w_cnt_nxt   = 3'd0;
                        end else begin
                            w_cnt_nxt = r_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_a         = '0;
        bus.mem_dout      = 8'd0;
        bus.mem_wr        = 1'b0;
        bus.if_finish_out = 1'b0;
        bus.if_data_out   = 32'd0;
        bus.lb_finish_out = 1'b0;
        bus.lb_data_out   = 32'd0;
        bus.st_finish_out = 1'b0;
        case (r_state)
            c_READ: begin
                if (r_cnt < w_beats) begin
                    bus.mem_a = w_beat_addr;
                end
            end
            c_WRITE: begin
                bus.mem_a    = w_beat_addr;
                bus.mem_dout = r_data[{r_cnt[1:0], 3'b000} +: 8];
                bus.mem_wr   = bus.rdy_in && !w_stall;
            end
            c_DONE: begin
                case (r_owner)
                    OWN_IF: begin
                        bus.if_finish_out = bus.rdy_in;
                        bus.if_data_out   = r_raw;
                    end
                    OWN_LD: begin
                        bus.lb_finish_out = bus.rdy_in;
                        bus.lb_data_out   = w_ext;
                    end
                    OWN_ST:  bus.st_finish_out = bus.rdy_in;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.st_rdy_out = (r_state == c_IDLE);

endmodule
`default_nettype wire
